regdump_monitor: RTL and testbench

//   Debug-monitor engine on the core's register-file debug read port (dbg_ra/dbg_rd).
//   On a start pulse it walks registers 0..NREGS-1 and emits each value as uppercase

---
 rtl/regdump_monitor.sv | 122 ++++++++++++
 tb/tb_regdump_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regdump_monitor.sv
// Register-file dump engine: walks registers 0..NREGS-1 over the debug read port and
// streams each value as uppercase ASCII hex plus EOL. Define REGDUMP_INDEX_EN for "II:" line prefixes.
module regdump_monitor #(
  parameter int          NREGS = 32,
  parameter logic [7:0]  EOL   = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  dbg_ra,
  input  logic [31:0] dbg_rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

`ifdef REGDUMP_INDEX_EN
  localparam int BYTES_PER_LINE = 12;
`else
  localparam int BYTES_PER_LINE = 9;
`endif
  localparam logic [3:0] LAST_NIB = 4'(BYTES_PER_LINE - 1);
  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SEND} state_t;

  state_t      state;
  logic [4:0]  idx;
  logic [3:0]  nib;
  logic [31:0] shr;

  logic [3:0]  nib_next;
  logic        digit_now;
  logic [31:0] shr_next;
  logic [7:0]  first_byte;
  logic [7:0]  next_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'd0, v}) : (8'h37 + {4'd0, v});
  endfunction

  // The shift register only advances past value digits, so the byte after a transfer
  // is always derived from the top nibble of the post-transfer shift register.
  always_comb begin
    nib_next = nib + 4'd1;
`ifdef REGDUMP_INDEX_EN
    digit_now = (nib > 4'd2) && (nib != LAST_NIB);
`else
    digit_now = (nib != LAST_NIB);
`endif
    shr_next   = digit_now ? {shr[27:0], 4'h0} : shr;
    first_byte = hex_char(dbg_rd[31:28]);
    next_byte  = (nib_next == LAST_NIB) ? EOL : hex_char(shr_next[31:28]);
`ifdef REGDUMP_INDEX_EN
    first_byte = hex_char({3'b000, idx[4]});
    if (nib_next == 4'd1) begin
      next_byte = hex_char(idx[3:0]);
    end else if (nib_next == 4'd2) begin
      next_byte = 8'h3A;
    end
`endif
  end

  // dbg_ra is set one edge ahead so the core's read data is valid throughout LATCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      dbg_ra   <= 5'd0;
      idx      <= 5'd0;
      nib      <= 4'd0;
      shr      <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dbg_ra <= 5'd0;
          if (start) begin
            idx   <= 5'd0;
            busy  <= 1'b1;
            state <= LATCH;
          end
        end
        LATCH: begin
          shr      <= dbg_rd;
          nib      <= 4'd0;
          tx_data  <= first_byte;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            if (nib == LAST_NIB) begin
              tx_valid <= 1'b0;
              if (idx == LAST_IDX) begin
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= 1'b1;
                dbg_ra <= 5'd0;
              end else begin
                idx    <= idx + 5'd1;
                dbg_ra <= idx + 5'd1;
                state  <= LATCH;
              end
            end else begin
              shr     <= shr_next;
              nib     <= nib_next;
              tx_data <= next_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regdump_monitor.sv
// Self-checking bench for regdump_monitor: byte stream compared against a register-file
// model that formats each value as hex text, plus timing, stall, restart and abort sequences.
module tb_regdump_monitor;

  localparam int NR = 32;
`ifdef REGDUMP_INDEX_EN
  localparam int B = 12;
`else
  localparam int B = 9;
`endif

  typedef struct {
    int          line;
    logic [31:0] value;
    string       digits;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] r [NR];
  logic [7:0]  rx [$];
  logic [7:0]  expQ [$];
  vec_t        vecs [8];

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  randReady = 1'b0;
  int  doneCount = 0;
  int  stallChecks = 0;
  int  stallBad = 0;
  bit  prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  regdump_monitor #(.NREGS(NR), .EOL(8'h0A)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  assign dbg_rd = r[dbg_ra];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = randReady ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Byte capture and stall-hold observation, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        stallChecks++;
        if (!(tx_valid && tx_data == prevData)) stallBad++;
      end
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      if (done) doneCount++;
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic vec_t mkVec(input int l, input logic [31:0] v, input string d);
    vec_t x;
    x.line = l;
    x.value = v;
    x.digits = d;
    return x;
  endfunction

  function automatic void buildExpected();
    expQ.delete();
    for (int i = 0; i < NR; i++) begin
`ifdef REGDUMP_INDEX_EN
      expQ.push_back(hexc(i / 16));
      expQ.push_back(hexc(i % 16));
      expQ.push_back(8'h3A);
`endif
      for (int k = 7; k >= 0; k--) expQ.push_back(hexc(int'((r[i] >> (4 * k)) & 32'hF)));
      expQ.push_back(8'h0A);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(output int sc);
    start = 1'b1;
    @(posedge clk);
    #1;
    sc = cyc;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int dcyc, output int busyBad);
    dcyc = -1;
    busyBad = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc + 1;
        break;
      end
      if (!busy) busyBad++;
    end
    checkOutput("done_seen", dcyc >= 0, 1);
  endtask

  task automatic checkStream(input string name, input int base, input int n);
    int bad;
    logic [7:0] got;
    checkOutput({name, "_len"}, rx.size() - base, n);
    bad = -1;
    for (int i = 0; i < n; i++) begin
      if (base + i >= rx.size() || rx[base + i] !== expQ[i]) begin
        bad = i;
        break;
      end
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      got = (base + bad < rx.size()) ? rx[base + bad] : 8'h00;
      $display("[TB] FAIL %s_bytes: byte %0d got %02h expected %02h", name, bad, got, expQ[bad]);
    end
  endtask

  task automatic checkLine(input string name, input int base, input int line, input string digits);
    logic [7:0] q [$];
    int off;
    int bad;
    logic [7:0] got;
`ifdef REGDUMP_INDEX_EN
    q.push_back(hexc(line / 16));
    q.push_back(hexc(line % 16));
    q.push_back(8'h3A);
`endif
    for (int k = 0; k < 8; k++) q.push_back(digits[k]);
    q.push_back(8'h0A);
    off = base + line * B;
    bad = -1;
    for (int k = 0; k < q.size(); k++) begin
      if (off + k >= rx.size() || rx[off + k] !== q[k]) begin
        bad = k;
        break;
      end
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      got = (off + bad < rx.size()) ? rx[off + bad] : 8'h00;
      $display("[TB] FAIL %s: line %0d byte %0d got %02h expected %02h", name, line, bad, got, q[bad]);
    end
  endtask

  task automatic runDump(input string tag, input int budget, output int sc, output int dc);
    int bb;
    applyStimulus(sc);
    @(negedge clk);
    checkOutput({tag, "_latch_busy"}, busy, 1);
    checkOutput({tag, "_latch_novalid"}, tx_valid, 0);
    @(negedge clk);
    checkOutput({tag, "_first_valid"}, tx_valid, 1);
    waitDone(budget, dc, bb);
    checkOutput({tag, "_busy_gaps"}, bb, 0);
  endtask

  initial begin : main
    int sc, dc, bb, base, d0, s0, sc2, dc2, dummy;

    vecs[0] = mkVec(0,  32'h00000000, "00000000");
    vecs[1] = mkVec(1,  32'h11111111, "11111111");
    vecs[2] = mkVec(10, 32'hDEADBEEF, "DEADBEEF");
    vecs[3] = mkVec(15, 32'hFFFFFFFF, "FFFFFFFF");
    vecs[4] = mkVec(16, 32'h11111110, "11111110");
    vecs[5] = mkVec(20, 32'h0123ABCD, "0123ABCD");
    vecs[6] = mkVec(25, 32'h80000001, "80000001");
    vecs[7] = mkVec(31, 32'h1111110F, "1111110F");

    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NR; i++) r[i] = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_dbg_ra", dbg_ra, 0);
    checkOutput("reset_tx_data", tx_data, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("idle_no_bytes", rx.size(), 0);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] full dump, ready always high");
    for (int i = 0; i < NR; i++) r[i] = i * 32'h11111111;
    r[10] = 32'hDEADBEEF;
    foreach (vecs[v]) r[vecs[v].line] = vecs[v].value;
    buildExpected();
    base = rx.size();
    d0 = doneCount;
    runDump("fast", 2000, sc, dc);
    checkOutput("fast_done_cycle", dc - sc, NR * (B + 1) + 1);
    checkStream("fast", base, NR * B);
    foreach (vecs[v]) checkLine("fast_line", base, vecs[v].line, vecs[v].digits);
    @(negedge clk);
    checkOutput("fast_done_pulse", done, 0);
    checkOutput("fast_done_count", doneCount - d0, 1);

    $display("[TB] full dump, ready random");
    randReady = 1'b1;
    base = rx.size();
    s0 = stallChecks;
    runDump("stall", 6000, sc, dc);
    checkStream("stall", base, NR * B);
    checkOutput("stall_hold", stallBad, 0);
    checkOutput("stalls_seen", stallChecks > s0, 1);
    randReady = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] start mid-dump and in done cycle");
    base = rx.size();
    d0 = doneCount;
    applyStimulus(sc);
    for (int i = 0; i < 400 && dbg_ra != 5'd5; i++) @(negedge clk);
    checkOutput("midstart_reached", dbg_ra, 5);
    applyStimulus(dummy);
    waitDone(2000, dc, bb);
    checkOutput("midstart_busy_gaps", bb, 0);
    checkOutput("midstart_done_cycle", dc - sc, NR * (B + 1) + 1);
    applyStimulus(sc2);
    checkOutput("midstart_done_count", doneCount - d0, 1);
    checkStream("midstart", base, NR * B);
    checkOutput("donecycle_start_busy", busy, 1);
    base = rx.size();
    waitDone(2000, dc2, bb);
    checkOutput("donecycle_done_cycle", dc2 - sc2, NR * (B + 1) + 1);
    checkStream("donecycle", base, NR * B);
    @(negedge clk);

    $display("[TB] reset in the middle of line 2");
    base = rx.size();
    applyStimulus(sc);
    for (int i = 0; i < 500 && (rx.size() - base) < 2 * B + 3; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx_valid", tx_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_dbg_ra", dbg_ra, 0);
    checkStream("abort", base, 2 * B + 3);
    repeat (10) @(negedge clk);
    checkOutput("abort_quiet", rx.size() - base, 2 * B + 3);
    base = rx.size();
    runDump("restart", 2000, sc, dc);
    checkOutput("restart_done_cycle", dc - sc, NR * (B + 1) + 1);
    checkStream("restart", base, NR * B);

    $display("[TB] random register contents");
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NR; i++) r[i] = $urandom;
      buildExpected();
      randReady = (t == 1);
      @(negedge clk);
      base = rx.size();
      runDump("rand", 6000, sc, dc);
      checkStream("rand", base, NR * B);
    end
    randReady = 1'b0;
    checkOutput("rand_stall_hold", stallBad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
